// File: rtl/repairclk_pattern_detector_if.sv
// Bus bundle for the RepairCLK receive-side pattern detector.
// Optional macro REPAIRCLK_DET_ERRCNT_EN adds the mismatch counter output.
interface repairclk_pattern_detector_if;
  logic       i_detect_en;
  logic       i_clear_log;
  logic       i_rckp;
  logic       i_rckn;
  logic       i_rtrk;
  logic [2:0] o_logged_results;
  logic       o_result_valid;
`ifdef REPAIRCLK_DET_ERRCNT_EN
  logic [7:0] o_mismatch_cnt;
`endif

  modport slave (
    input  i_detect_en, i_clear_log, i_rckp, i_rckn, i_rtrk,
    output o_logged_results, o_result_valid
`ifdef REPAIRCLK_DET_ERRCNT_EN
    , output o_mismatch_cnt
`endif
  );

  modport master (
    output i_detect_en, i_clear_log, i_rckp, i_rckn, i_rtrk,
    input  o_logged_results, o_result_valid
`ifdef REPAIRCLK_DET_ERRCNT_EN
    , input o_mismatch_cnt
`endif
  );
endinterface

// File: rtl/repairclk_pattern_detector.sv
// MBINIT.RepairCLK receive-side clock repair pattern detector: three lane FSMs with sticky pass bits.
// Define REPAIRCLK_DET_ERRCNT_EN to add the saturating cross-lane mismatch counter.
module repairclk_pattern_detector #(
  parameter int TGL_UI      = 32,
  parameter int LOW_UI      = 16,
  parameter int ITER_THRESH = 16
) (
  input logic                       i_clk,
  input logic                       i_rst,
  repairclk_pattern_detector_if.slave bus
);

  localparam int PMAX = (TGL_UI > LOW_UI) ? TGL_UI : LOW_UI;
  localparam int PW   = (PMAX > 1) ? $clog2(PMAX) : 1;
  localparam int CW   = $clog2(ITER_THRESH + 1);
  localparam logic [PW-1:0] TGL_LAST = PW'(TGL_UI - 1);
  localparam logic [PW-1:0] LOW_LAST = PW'(LOW_UI - 1);
  localparam logic [CW-1:0] THRESH   = CW'(ITER_THRESH);

  typedef enum logic [1:0] {HUNT, TGL, LOW} state_e;

  state_e        state_q [3];
  state_e        state_d [3];
  logic [PW-1:0] pos_q   [3];
  logic [PW-1:0] pos_d   [3];
  logic [CW-1:0] cnt_q   [3];
  logic [CW-1:0] cnt_d   [3];
  logic [2:0]    pass_q, pass_d;
  logic [2:0]    smp;
  logic          det_q, det_d;
  logic          valid_q, valid_d;
  logic          idle;
`ifdef REPAIRCLK_DET_ERRCNT_EN
  logic [2:0]    mm;
  logic [8:0]    mm_sum;
  logic [7:0]    mm_cnt_q, mm_cnt_d;
`endif

  assign smp  = {bus.i_rtrk, bus.i_rckn, bus.i_rckp};
  assign idle = bus.i_clear_log || !bus.i_detect_en;

  // Per-lane tracker: position p is the index of the next expected sample.
  always_comb begin
    for (int l = 0; l < 3; l++) begin
      state_d[l] = state_q[l];
      pos_d[l]   = pos_q[l];
      cnt_d[l]   = cnt_q[l];
`ifdef REPAIRCLK_DET_ERRCNT_EN
      mm[l]      = 1'b0;
`endif
      if (idle) begin
        state_d[l] = HUNT;
        pos_d[l]   = '0;
        cnt_d[l]   = '0;
      end else begin
        case (state_q[l])
          HUNT: begin
            if (smp[l]) begin
              state_d[l] = TGL;
              pos_d[l]   = PW'(1);
            end
          end
          TGL: begin
            if (smp[l] == ~pos_q[l][0]) begin
              if (pos_q[l] == TGL_LAST) begin
                state_d[l] = LOW;
                pos_d[l]   = '0;
              end else begin
                pos_d[l] = pos_q[l] + PW'(1);
              end
            end else begin
              state_d[l] = HUNT;
              pos_d[l]   = '0;
              cnt_d[l]   = '0;
`ifdef REPAIRCLK_DET_ERRCNT_EN
              mm[l]      = 1'b1;
`endif
            end
          end
          LOW: begin
            if (!smp[l]) begin
              if (pos_q[l] == LOW_LAST) begin
                state_d[l] = TGL;
                pos_d[l]   = '0;
                cnt_d[l]   = (cnt_q[l] == THRESH) ? cnt_q[l] : cnt_q[l] + CW'(1);
              end else begin
                pos_d[l] = pos_q[l] + PW'(1);
              end
            end else begin
              // Early 1 is treated as the start of a new iteration.
              state_d[l] = TGL;
              pos_d[l]   = PW'(1);
              cnt_d[l]   = '0;
`ifdef REPAIRCLK_DET_ERRCNT_EN
              mm[l]      = 1'b1;
`endif
            end
          end
          default: begin
            state_d[l] = HUNT;
            pos_d[l]   = '0;
            cnt_d[l]   = '0;
          end
        endcase
      end
      pass_d[l] = bus.i_clear_log ? 1'b0 : (pass_q[l] || (cnt_d[l] == THRESH));
    end
  end

  always_comb begin
    det_d   = bus.i_detect_en;
    valid_d = valid_q;
    if (bus.i_clear_log) begin
      valid_d = 1'b0;
    end else if (det_q && !bus.i_detect_en) begin
      valid_d = 1'b1;
    end else if (!det_q && bus.i_detect_en) begin
      valid_d = 1'b0;
    end
  end

`ifdef REPAIRCLK_DET_ERRCNT_EN
  always_comb begin
    mm_sum   = 9'(mm_cnt_q) + 9'(mm[0]) + 9'(mm[1]) + 9'(mm[2]);
    mm_cnt_d = bus.i_clear_log ? 8'h00 : ((mm_sum > 9'd255) ? 8'hFF : mm_sum[7:0]);
  end
`endif

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int l = 0; l < 3; l++) begin
        state_q[l] <= HUNT;
        pos_q[l]   <= '0;
        cnt_q[l]   <= '0;
      end
      pass_q   <= '0;
      det_q    <= 1'b0;
      valid_q  <= 1'b0;
`ifdef REPAIRCLK_DET_ERRCNT_EN
      mm_cnt_q <= '0;
`endif
    end else begin
      for (int l = 0; l < 3; l++) begin
        state_q[l] <= state_d[l];
        pos_q[l]   <= pos_d[l];
        cnt_q[l]   <= cnt_d[l];
      end
      pass_q   <= pass_d;
      det_q    <= det_d;
      valid_q  <= valid_d;
`ifdef REPAIRCLK_DET_ERRCNT_EN
      mm_cnt_q <= mm_cnt_d;
`endif
    end
  end

  assign bus.o_logged_results = pass_q;
  assign bus.o_result_valid   = valid_q;
`ifdef REPAIRCLK_DET_ERRCNT_EN
  assign bus.o_mismatch_cnt   = mm_cnt_q;
`endif

endmodule

// File: tb/tb_repairclk_pattern_detector.sv
// Directed bench for repairclk_pattern_detector with default parameters (48-sample iterations, threshold 16).
// Mismatch-counter checks are included when REPAIRCLK_DET_ERRCNT_EN is defined.
module tb_repairclk_pattern_detector;
  localparam int ITER = 48;
  localparam int TGL  = 32;

  logic clk = 1'b0;
  logic rst;
  int   n_compared   = 0;
  int   n_mismatched = 0;

  repairclk_pattern_detector_if dut_if ();

  repairclk_pattern_detector dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (dut_if)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_compared++;
    if (got !== exp) begin
      n_mismatched++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // One sample per clock; outputs are read 1 time unit after the edge.
  task automatic applyStimulus(input logic det, input logic clr, input logic p, input logic n, input logic t);
    dut_if.i_detect_en = det;
    dut_if.i_clear_log = clr;
    dut_if.i_rckp      = p;
    dut_if.i_rckn      = n;
    dut_if.i_rtrk      = t;
    @(posedge clk);
    #1;
  endtask

  // Samples numbered from 0; iterations numbered from 1. A flip inverts RCKN at the last toggle position.
  task automatic runPattern(input int first, input int count, input logic rtrk_stuck,
                            input int flip1, input int flip2);
    for (int k = first; k < first + count; k++) begin
      int   it;
      int   ph;
      logic b;
      logic bn;
      it = k / ITER + 1;
      ph = k % ITER;
      b  = (ph < TGL) ? ~ph[0] : 1'b0;
      bn = b ^ ((ph == TGL - 1) && (it == flip1 || it == flip2));
      applyStimulus(1'b1, 1'b0, b, bn, rtrk_stuck ? 1'b0 : b);
    end
  endtask

  task automatic clearAll();
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    rst = 1'b1;
    dut_if.i_detect_en = 1'b0;
    dut_if.i_clear_log = 1'b0;
    dut_if.i_rckp      = 1'b0;
    dut_if.i_rckn      = 1'b0;
    dut_if.i_rtrk      = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset_results", 8'(dut_if.o_logged_results), 8'h00);
    checkOutput("reset_valid", 8'(dut_if.o_result_valid), 8'h00);
`ifdef REPAIRCLK_DET_ERRCNT_EN
    checkOutput("reset_mmcnt", dut_if.o_mismatch_cnt, 8'h00);
`endif
    rst = 1'b0;

    $display("[TB] clean pattern, 128 iterations");
    runPattern(0, 767, 1'b0, 0, 0);
    checkOutput("clean_before_767", 8'(dut_if.o_logged_results), 8'h00);
    runPattern(767, 1, 1'b0, 0, 0);
    checkOutput("clean_at_768", 8'(dut_if.o_logged_results), 8'h07);
    runPattern(768, 128 * ITER - 768, 1'b0, 0, 0);
    checkOutput("clean_valid_in_window", 8'(dut_if.o_result_valid), 8'h00);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("clean_valid_after_drop", 8'(dut_if.o_result_valid), 8'h01);
    checkOutput("clean_results_held", 8'(dut_if.o_logged_results), 8'h07);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("clean_valid_sticky", 8'(dut_if.o_result_valid), 8'h01);
`ifdef REPAIRCLK_DET_ERRCNT_EN
    checkOutput("clean_mmcnt", dut_if.o_mismatch_cnt, 8'h00);
`endif
    clearAll();
    checkOutput("clear_results", 8'(dut_if.o_logged_results), 8'h00);
    checkOutput("clear_valid", 8'(dut_if.o_result_valid), 8'h00);

    $display("[TB] RTRK stuck low");
    runPattern(0, 20 * ITER, 1'b1, 0, 0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("stuck_results", 8'(dut_if.o_logged_results), 8'h03);
    checkOutput("stuck_valid", 8'(dut_if.o_result_valid), 8'h01);
`ifdef REPAIRCLK_DET_ERRCNT_EN
    checkOutput("stuck_mmcnt", dut_if.o_mismatch_cnt, 8'h00);
`endif
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("rise_clears_valid", 8'(dut_if.o_result_valid), 8'h00);
    checkOutput("rise_keeps_pass", 8'(dut_if.o_logged_results), 8'h03);
    clearAll();
    checkOutput("clear_beats_fall_valid", 8'(dut_if.o_result_valid), 8'h00);
    checkOutput("clear_beats_fall_results", 8'(dut_if.o_logged_results), 8'h00);

    $display("[TB] RCKN flipped in iterations 5 and 110");
    runPattern(0, 20 * ITER, 1'b0, 5, 110);
    checkOutput("flip_iter20", 8'(dut_if.o_logged_results), 8'h05);
    runPattern(20 * ITER, ITER, 1'b0, 5, 110);
    checkOutput("flip_iter21", 8'(dut_if.o_logged_results), 8'h07);
    runPattern(21 * ITER, 112 * ITER - 21 * ITER, 1'b0, 5, 110);
    checkOutput("flip_after_110", 8'(dut_if.o_logged_results), 8'h07);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("flip_valid", 8'(dut_if.o_result_valid), 8'h01);
`ifdef REPAIRCLK_DET_ERRCNT_EN
    checkOutput("flip_mmcnt", dut_if.o_mismatch_cnt, 8'h02);
`endif
    clearAll();

    $display("[TB] only 15 iterations");
    runPattern(0, 15 * ITER, 1'b0, 0, 0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("short_results", 8'(dut_if.o_logged_results), 8'h00);
    checkOutput("short_valid", 8'(dut_if.o_result_valid), 8'h01);
    clearAll();

    $display("[TB] clear on the completing sample");
    runPattern(0, 16 * ITER - 1, 1'b0, 0, 0);
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    checkOutput("clear_race_results", 8'(dut_if.o_logged_results), 8'h00);
    runPattern(16 * ITER, 16 * ITER - 1, 1'b0, 0, 0);
    checkOutput("clear_race_rerun_short", 8'(dut_if.o_logged_results), 8'h00);
    runPattern(32 * ITER - 1, 1, 1'b0, 0, 0);
    checkOutput("clear_race_rerun_pass", 8'(dut_if.o_logged_results), 8'h07);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("clear_race_valid", 8'(dut_if.o_result_valid), 8'h01);

    $display("[TB] reset in iteration 10");
    runPattern(0, 9 * ITER + 20, 1'b0, 0, 0);
    checkOutput("pre_reset_pass_held", 8'(dut_if.o_logged_results), 8'h07);
    checkOutput("pre_reset_valid", 8'(dut_if.o_result_valid), 8'h00);
    rst = 1'b1;
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b1, 1'b1);
    rst = 1'b0;
    checkOutput("mid_reset_results", 8'(dut_if.o_logged_results), 8'h00);
    checkOutput("mid_reset_valid", 8'(dut_if.o_result_valid), 8'h00);
    runPattern(9 * ITER + 21, 26 * ITER - 1 - (9 * ITER + 21), 1'b0, 0, 0);
    checkOutput("post_reset_short", 8'(dut_if.o_logged_results), 8'h00);
    runPattern(26 * ITER - 1, 1, 1'b0, 0, 0);
    checkOutput("post_reset_pass", 8'(dut_if.o_logged_results), 8'h07);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("post_reset_valid", 8'(dut_if.o_result_valid), 8'h01);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end
endmodule
